// File: rtl/mux_nto1_hs_if.sv
// mux_nto1_hs_if: per-channel input streams, select controls and output stream.
// slave is the mux side; master is the producer/consumer side.
interface mux_nto1_hs_if #(
   parameter int  N_CH   = 8,
   parameter int  DATA_W = 8,
   localparam int SEL_W  = $clog2(N_CH)
);
   logic                     mode;
   logic [SEL_W-1:0]         sel;
   logic [N_CH*DATA_W-1:0]   in_data;
   logic [N_CH-1:0]          in_valid;
   logic [N_CH-1:0]          in_ready;
   logic [DATA_W-1:0]        out_data;
   logic [SEL_W-1:0]         out_ch;
   logic                     out_valid;
   logic                     out_ready;
   logic                     sel_err;

   modport slave (
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_ch, out_valid, sel_err
   );

   modport master (
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_ch, out_valid, sel_err
   );
endinterface

// File: rtl/mux_nto1_hs.sv
// mux_nto1_hs: registered N-to-1 stream mux with SEL or round-robin grant.
// Define MUX_XFER_CNT_EN to add cnt_clr / xfer_cnt (saturating pop counter).
module mux_nto1_hs #(
   parameter int  N_CH   = 8,
   parameter int  DATA_W = 8,
   localparam int SEL_W  = $clog2(N_CH)
) (
   input  logic        clk,
   input  logic        rst,
`ifdef MUX_XFER_CNT_EN
   input  logic        cnt_clr,
   output logic [15:0] xfer_cnt,
`endif
   mux_nto1_hs_if.slave bus
);

   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0]  out_ch_q, out_ch_d;
   logic              out_valid_q, out_valid_d;
   logic              sel_err_q, sel_err_d;
   logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic              load;
   logic              sel_ok;
   logic              gnt_vld;
   logic [SEL_W-1:0]  gnt_idx;
   logic              xfer;
   logic [N_CH-1:0]   rdy;
   logic [DATA_W-1:0] gnt_data;

   assign load   = !out_valid_q || bus.out_ready;
   assign sel_ok = int'(bus.sel) < N_CH;

   always_comb begin : grant
      int               idx;
      logic [SEL_W-1:0] cand;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      cand    = '0;
      if (!bus.mode) begin
         gnt_vld = sel_ok;
         gnt_idx = bus.sel;
      end else begin
         // descending scan: the closest valid channel at/after rr_ptr wins last
         for (int k = N_CH - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            cand = SEL_W'(idx);
            if (bus.in_valid[cand]) begin
               gnt_vld = 1'b1;
               gnt_idx = cand;
            end
         end
      end
   end

   always_comb begin
      rdy = '0;
      if (gnt_vld && load && !rst) rdy[gnt_idx] = 1'b1;
   end

   assign bus.in_ready = rdy;
   assign xfer = gnt_vld && load && !rst && bus.in_valid[gnt_idx];

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (gnt_idx == SEL_W'(i)) gnt_data = bus.in_data[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      rr_ptr_d    = rr_ptr_q;
      sel_err_d   = !bus.mode && !sel_ok;
      if (xfer) begin
         out_data_d  = gnt_data;
         out_ch_d    = gnt_idx;
         out_valid_d = 1'b1;
         if (bus.mode) begin
            rr_ptr_d = (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         sel_err_q   <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         sel_err_q   <= sel_err_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sel_err   = sel_err_q;

`ifdef MUX_XFER_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (out_valid_q && bus.out_ready && cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_nto1_hs.sv
// tb_mux_nto1_hs: directed scenarios on 8- and 6-channel muxes plus a
// randomized soak scored against a queue-based reference model.
`timescale 1ns/1ps
module tb_mux_nto1_hs;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_run  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mux_nto1_hs_if #(.N_CH(8), .DATA_W(8)) b8 ();
   mux_nto1_hs_if #(.N_CH(6), .DATA_W(8)) b6 ();

`ifdef MUX_XFER_CNT_EN
   logic        cnt_clr8 = 1'b0;
   logic        cnt_clr6 = 1'b0;
   logic [15:0] cnt8, cnt6;
`endif

   mux_nto1_hs #(.N_CH(8), .DATA_W(8)) dut8 (
      .clk     (clk),
      .rst     (rst),
`ifdef MUX_XFER_CNT_EN
      .cnt_clr (cnt_clr8),
      .xfer_cnt(cnt8),
`endif
      .bus     (b8)
   );

   mux_nto1_hs #(.N_CH(6), .DATA_W(8)) dut6 (
      .clk     (clk),
      .rst     (rst),
`ifdef MUX_XFER_CNT_EN
      .cnt_clr (cnt_clr6),
      .xfer_cnt(cnt6),
`endif
      .bus     (b6)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      b8.mode = 1'b0; b8.sel = 3'd3; b8.in_valid = '1;
      b8.in_data = {8{8'h77}}; b8.out_ready = 1'b1;
      b6.mode = 1'b0; b6.sel = 3'd0; b6.in_valid = '1;
      b6.in_data = {6{8'h66}}; b6.out_ready = 1'b1;
      tick();
      tick();
      n_run++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0h want 0", b8.out_valid); end
      n_run++; if (b8.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %0h want 0", b8.out_data); end
      n_run++; if (b8.out_ch !== 3'd0) begin n_fail++; $display("FAIL rst_ch: got %0h want 0", b8.out_ch); end
      n_run++; if (b8.sel_err !== 1'b0) begin n_fail++; $display("FAIL rst_selerr: got %0h want 0", b8.sel_err); end
      n_run++; if (b8.in_ready !== 8'h00) begin n_fail++; $display("FAIL rst_inrdy: got %0h want 0", b8.in_ready); end
      n_run++; if (b6.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid6: got %0h want 0", b6.out_valid); end
`ifdef MUX_XFER_CNT_EN
      n_run++; if (cnt8 !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0h want 0", cnt8); end
`endif
   endtask

   task automatic test_sel_mode();
      rst = 1'b0;
      b6.in_valid = '0;
      b8.mode = 1'b0; b8.sel = 3'd3; b8.in_valid = 8'b0000_1000;
      b8.in_data = {8{8'h11}}; b8.in_data[3*8 +: 8] = 8'hA5;
      b8.out_ready = 1'b1;
      #2;
      n_run++; if (b8.in_ready !== 8'b0000_1000) begin n_fail++; $display("FAIL sel_inrdy: got %0h want 08", b8.in_ready); end
      tick();
      n_run++; if (b8.out_data !== 8'hA5) begin n_fail++; $display("FAIL sel_data: got %0h want a5", b8.out_data); end
      n_run++; if (b8.out_ch !== 3'd3) begin n_fail++; $display("FAIL sel_ch: got %0h want 3", b8.out_ch); end
      n_run++; if (b8.out_valid !== 1'b1) begin n_fail++; $display("FAIL sel_valid: got %0h want 1", b8.out_valid); end
      n_run++; if (b8.sel_err !== 1'b0) begin n_fail++; $display("FAIL sel_selerr: got %0h want 0", b8.sel_err); end
   endtask

   task automatic test_backpressure();
      b8.out_ready = 1'b0;
      b8.in_data[3*8 +: 8] = 8'h3C;
      #2;
      n_run++; if (b8.in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_inrdy: got %0h want 0", b8.in_ready); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_run++; if (b8.out_data !== 8'hA5 || b8.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %0h/%0h want a5/1", b8.out_data, b8.out_valid); end
      end
      b8.out_ready = 1'b1;
      #2;
      n_run++; if (b8.in_ready !== 8'b0000_1000) begin n_fail++; $display("FAIL bp_release_rdy: got %0h want 08", b8.in_ready); end
      tick();
      n_run++; if (b8.out_data !== 8'h3C || b8.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next: got %0h/%0h want 3c/1", b8.out_data, b8.out_valid); end
      b8.in_valid = '0;
      tick();
      n_run++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0h want 0", b8.out_valid); end
   endtask

   task automatic test_rr_fair();
      int seq [6] = '{0, 2, 7, 0, 2, 7};
      b8.in_valid = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      b8.mode = 1'b1; b8.sel = 3'd5; b8.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) b8.in_data[i*8 +: 8] = 8'h10 + 8'(i);
      b8.in_valid = 8'b1000_0101;
      for (int j = 0; j < 6; j++) begin
         #2;
         n_run++; if (b8.in_ready !== (8'h01 << seq[j])) begin n_fail++; $display("FAIL rr_rdy%0d: got %0h want %0h", j, b8.in_ready, 8'h01 << seq[j]); end
         tick();
         n_run++; if (b8.out_ch !== 3'(seq[j]) || b8.out_data !== 8'h10 + 8'(seq[j])) begin n_fail++; $display("FAIL rr_seq%0d: got ch%0d/%0h want ch%0d", j, b8.out_ch, b8.out_data, seq[j]); end
      end
   endtask

   task automatic test_rr_wrap();
      b8.in_valid = 8'b0100_0000;
      #2;
      n_run++; if (b8.in_ready !== 8'h40) begin n_fail++; $display("FAIL wrap_rdy6: got %0h want 40", b8.in_ready); end
      tick();
      n_run++; if (b8.out_ch !== 3'd6) begin n_fail++; $display("FAIL wrap_ch6: got %0h want 6", b8.out_ch); end
      b8.in_valid = 8'b0000_0010;
      #2;
      n_run++; if (b8.in_ready !== 8'h02) begin n_fail++; $display("FAIL wrap_rdy1: got %0h want 02", b8.in_ready); end
      tick();
      n_run++; if (b8.out_ch !== 3'd1 || b8.out_data !== 8'h11) begin n_fail++; $display("FAIL wrap_ch1: got %0h/%0h want 1/11", b8.out_ch, b8.out_data); end
      b8.in_valid = 8'b0000_0111;
      #2;
      n_run++; if (b8.in_ready !== 8'h04) begin n_fail++; $display("FAIL wrap_ptr2: got %0h want 04", b8.in_ready); end
      tick();
      b8.in_valid = '0;
      #2;
      n_run++; if (b8.in_ready !== 8'h00) begin n_fail++; $display("FAIL idle_rdy: got %0h want 0", b8.in_ready); end
      tick();
      n_run++; if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %0h want 0", b8.out_valid); end
   endtask

   task automatic test_oob_sel();
      b6.mode = 1'b0; b6.sel = 3'd2; b6.out_ready = 1'b1;
      b6.in_data = {6{8'h00}}; b6.in_data[2*8 +: 8] = 8'h5A;
      b6.in_valid = 6'b00_0100;
      tick();
      n_run++; if (b6.out_data !== 8'h5A || b6.out_valid !== 1'b1) begin n_fail++; $display("FAIL oob_load: got %0h/%0h want 5a/1", b6.out_data, b6.out_valid); end
      b6.out_ready = 1'b0; b6.sel = 3'd7;
      b6.in_valid = '1; b6.in_data = {6{8'hEE}};
      #2;
      n_run++; if (b6.in_ready !== 6'h00) begin n_fail++; $display("FAIL oob_rdy_bp: got %0h want 0", b6.in_ready); end
      tick();
      n_run++; if (b6.sel_err !== 1'b1) begin n_fail++; $display("FAIL oob_err: got %0h want 1", b6.sel_err); end
      n_run++; if (b6.out_data !== 8'h5A || b6.out_valid !== 1'b1) begin n_fail++; $display("FAIL oob_hold: got %0h/%0h want 5a/1", b6.out_data, b6.out_valid); end
      b6.out_ready = 1'b1;
      #2;
      n_run++; if (b6.in_ready !== 6'h00) begin n_fail++; $display("FAIL oob_rdy: got %0h want 0", b6.in_ready); end
      tick();
      n_run++; if (b6.out_valid !== 1'b0 || b6.sel_err !== 1'b1) begin n_fail++; $display("FAIL oob_drop: got v%0h e%0h want v0 e1", b6.out_valid, b6.sel_err); end
      b6.sel = 3'd6;
      tick();
      n_run++; if (b6.sel_err !== 1'b1 || b6.out_valid !== 1'b0) begin n_fail++; $display("FAIL oob_sel6: got e%0h v%0h want e1 v0", b6.sel_err, b6.out_valid); end
      b6.sel = 3'd5;
      #2;
      n_run++; if (b6.in_ready !== 6'b10_0000) begin n_fail++; $display("FAIL oob_sel5_rdy: got %0h want 20", b6.in_ready); end
      tick();
      n_run++; if (b6.sel_err !== 1'b0 || b6.out_ch !== 3'd5 || b6.out_data !== 8'hEE) begin n_fail++; $display("FAIL oob_sel5: got e%0h ch%0h d%0h want e0 ch5 dee", b6.sel_err, b6.out_ch, b6.out_data); end
      b6.mode = 1'b1; b6.sel = 3'd7; b6.in_valid = 6'b00_0001;
      #2;
      n_run++; if (b6.in_ready !== 6'h01) begin n_fail++; $display("FAIL oob_rr_rdy: got %0h want 01", b6.in_ready); end
      tick();
      n_run++; if (b6.sel_err !== 1'b0 || b6.out_ch !== 3'd0) begin n_fail++; $display("FAIL oob_rr: got e%0h ch%0h want e0 ch0", b6.sel_err, b6.out_ch); end
      b6.in_valid = '0;
   endtask

   task automatic test_soak();
      int          q_ch [$];
      logic [7:0]  q_d  [$];
      int          rr;
      int          g;
      int          c;
      logic        full, ld, pop, push;
      logic [7:0]  exp_rdy;
      logic [15:0] mcnt;
      logic        clr;
      rst = 1'b1;
      b8.in_valid = '0;
      tick();
      rst = 1'b0;
      rr = 0;
      mcnt = 16'd0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         b8.mode      = 1'($urandom_range(0, 1));
         b8.sel       = 3'($urandom_range(0, 7));
         b8.in_valid  = 8'($urandom);
         b8.in_data   = {$urandom, $urandom};
         b8.out_ready = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 63) == 0);
`ifdef MUX_XFER_CNT_EN
         cnt_clr8 = clr;
`endif
         #2;
         full = (q_ch.size() != 0);
         ld   = !full || b8.out_ready;
         g    = -1;
         if (!b8.mode) begin
            g = int'(b8.sel);
         end else begin
            for (int k = 0; k < 8; k++) begin
               c = (rr + k) % 8;
               if (b8.in_valid[c]) begin
                  g = c;
                  break;
               end
            end
         end
         exp_rdy = 8'h00;
         if (g >= 0 && ld) exp_rdy = 8'h01 << g;
         n_run++; if (b8.in_ready !== exp_rdy) begin n_fail++; $display("FAIL soak_rdy@%0d: got %0h want %0h", cyc, b8.in_ready, exp_rdy); end
         pop  = full && b8.out_ready;
         push = (g >= 0) && ld && b8.in_valid[g];
         if (pop) begin
            void'(q_ch.pop_front());
            void'(q_d.pop_front());
         end
         if (clr) mcnt = 16'd0;
         else if (pop && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
         if (push) begin
            q_ch.push_back(g);
            q_d.push_back(b8.in_data[g*8 +: 8]);
            if (b8.mode) rr = (g + 1) % 8;
         end
         tick();
         n_run++; if (b8.out_valid !== (q_ch.size() != 0)) begin n_fail++; $display("FAIL soak_valid@%0d: got %0h want %0h", cyc, b8.out_valid, q_ch.size() != 0); end
         if (q_ch.size() != 0) begin
            n_run++; if (b8.out_ch !== 3'(q_ch[0]) || b8.out_data !== q_d[0]) begin n_fail++; $display("FAIL soak_word@%0d: got ch%0d/%0h want ch%0d/%0h", cyc, b8.out_ch, b8.out_data, q_ch[0], q_d[0]); end
         end
`ifdef MUX_XFER_CNT_EN
         n_run++; if (cnt8 !== mcnt) begin n_fail++; $display("FAIL soak_cnt@%0d: got %0d want %0d", cyc, cnt8, mcnt); end
`endif
      end
      b8.in_valid = '0;
`ifdef MUX_XFER_CNT_EN
      cnt_clr8 = 1'b0;
`endif
   endtask

   initial begin
      test_reset();
      test_sel_mode();
      test_backpressure();
      test_rr_fair();
      test_rr_wrap();
      test_oob_sel();
      test_soak();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_nto1_hs.md
Name: mux_nto1_hs

Overview:
Parametrised, registered N-to-1 channel multiplexer with valid/ready handshakes on every input and on the output. It is the successor to the 8:1 single-bit mux. It adds multi-bit channels, a configurable channel count, a runtime select-or-round-robin mode and a backpressured output register. It sits between several producer streams and one consumer.

Parameters:
N_CH, 8, number of input channels (2..16)
DATA_W, 8, bits per channel
SEL_W, $clog2(N_CH), width of sel and out_ch (derived; do not override)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
mode  in  1  0 = SEL (explicit select), 1 = RR (round-robin over valid channels)
sel  in  SEL_W  channel index, used only when mode=0
in_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
in_valid  in  N_CH  per-channel valid
in_ready  out  N_CH  per-channel ready (combinational)
out_data  out  DATA_W  registered selected data
out_ch  out  SEL_W  registered index of the channel that supplied out_data
out_valid  out  1  registered output valid
out_ready  in  1  consumer ready
sel_err  out  1  registered; high one cycle after an out-of-range sel

Behaviour:
- Reset (rst=1 at posedge): out_data=0, out_ch=0, out_valid=0, sel_err=0, rr_ptr=0. in_ready is all-zero while out_valid=0 and rst=1. Reset mid-transfer discards the held word; no partial state survives.
- load = !out_valid | out_ready. This is the output register's capacity to accept a word this cycle.
- Grant, mode=0:
  - grant = sel when sel < N_CH.
  - If sel >= N_CH (only possible when N_CH is not a power of 2): no grant, in_ready=0, and sel_err=1 on the next cycle. Otherwise sel_err=0.
- Grant, mode=1:
  - grant = first i with in_valid[i]=1, searching circularly from rr_ptr upward and wrapping N_CH-1 -> 0.
  - No valid channel -> no grant.
  - sel is ignored; sel_err=0.
- in_ready[g] = load & grant_exists, for the granted index g only. All other bits are 0. in_ready must not depend on in_valid[g] in mode 0.
- Transfer on channel g when in_valid[g] & in_ready[g]. At that posedge: out_data <= channel g data, out_ch <= g, out_valid <= 1.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 word per cycle while out_ready=1.
- Output handshake:
  - Completes when out_valid & out_ready.
  - If there is no new transfer in the same cycle, out_valid <= 0.
  - Simultaneous output pop and input transfer: new word loaded, out_valid stays 1 with no bubble.
- Backpressure (out_valid=1, out_ready=0): out_data and out_ch are held stable and all in_ready=0.
- rr_ptr:
  - Updates only on a transfer in mode 1: rr_ptr <= g+1, wrapping to 0 after N_CH-1.
  - Unchanged in mode 0 and when no transfer occurs.
- mode or sel changes take effect in the same cycle's grant. A word already in the output register is unaffected.
- in_data of non-granted channels never reaches out_data.

Optional Feature:
MUX_XFER_CNT_EN
- Defined:
  - Adds output port xfer_cnt [15:0], which increments by 1 on each output handshake (out_valid & out_ready).
  - Saturates at 16'hFFFF and is cleared to 0 by rst.
  - Also adds input cnt_clr (1 bit, synchronous clear). On the same cycle as a handshake, clear wins.
- Not defined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
1. Reset, SEL mode: rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, sel_err=0. After rst=0: mode=0, sel=3, ch3=8'hA5, out_ready=1 -> in_ready=8'b0000_1000; next cycle out_data=8'hA5, out_ch=3, out_valid=1.
2. Backpressure: out_ready=0 after the word 8'hA5 is loaded, ch3 changes to 8'h3C -> in_ready=0, out_data holds 8'hA5 for 5 cycles. Raise out_ready -> 8'h3C appears on the next cycle with no duplicate of 8'hA5.
3. Round-robin fairness: mode=1, in_valid=8'b1000_0101 held, out_ready=1 -> out_ch sequence 0,2,7,0,2,7. Each channel is granted exactly once per 3 cycles.
4. RR wrap and sparse valids: rr_ptr=7 (after granting ch6), only in_valid[1]=1 -> grant ch1, rr_ptr becomes 2. All in_valid=0 -> out_valid drops after the pending pop.
5. Out-of-range select: N_CH=6, mode=0, sel=7 -> in_ready=0, sel_err=1 on the next cycle, out_valid unchanged by new data.
6. Random soak (1000 cycles, $random on data/valid/sel/mode/out_ready) -> scoreboard matches every output word to its input handshake by channel, and no out_data change occurs while out_valid & !out_ready. With MUX_XFER_CNT_EN defined, xfer_cnt equals the scoreboard pop count.
